// File: rtl/nasti_bram_ctrl.sv
// rtl/nasti_bram_ctrl.sv - NASTI (AXI4) slave to single-port block-RAM controller
//
// Purpose: bridges one NASTI slave port onto a single-port BRAM. Handles
// FIXED/INCR/WRAP bursts and narrow transfers, and alternates priority between
// contending read and write requests. Read data comes back through a small
// FIFO so that R-channel backpressure never loses a RAM word.
//
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_aw_* / o_aw_ready      write address channel
//   i_w_*  / o_w_ready       write data channel
//   o_b_*  / i_b_ready       write response channel
//   i_ar_* / o_ar_ready      read address channel
//   o_r_*  / i_r_ready       read data channel
//   o_ram_en, o_ram_we       RAM enable and byte write enables (we == 0 is a read)
//   o_ram_addr               RAM word address
//   o_ram_wrdata             RAM write data
//   i_ram_rddata             RAM read data, RAM_LATENCY cycles after a read enable
module nasti_bram_ctrl #(
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 128,
    parameter int RAM_LATENCY = 1
) (
    input  logic                                        i_clk,
    input  logic                                        i_rstn,
    input  logic [ID_WIDTH-1:0]                         i_aw_id,
    input  logic [ADDR_WIDTH-1:0]                       i_aw_addr,
    input  logic [7:0]                                  i_aw_len,
    input  logic [2:0]                                  i_aw_size,
    input  logic [1:0]                                  i_aw_burst,
    input  logic                                        i_aw_valid,
    output logic                                        o_aw_ready,
    input  logic [DATA_WIDTH-1:0]                       i_w_data,
    input  logic [DATA_WIDTH/8-1:0]                     i_w_strb,
    input  logic                                        i_w_last,
    input  logic                                        i_w_valid,
    output logic                                        o_w_ready,
    output logic [ID_WIDTH-1:0]                         o_b_id,
    output logic [1:0]                                  o_b_resp,
    output logic                                        o_b_valid,
    input  logic                                        i_b_ready,
    input  logic [ID_WIDTH-1:0]                         i_ar_id,
    input  logic [ADDR_WIDTH-1:0]                       i_ar_addr,
    input  logic [7:0]                                  i_ar_len,
    input  logic [2:0]                                  i_ar_size,
    input  logic [1:0]                                  i_ar_burst,
    input  logic                                        i_ar_valid,
    output logic                                        o_ar_ready,
    output logic [ID_WIDTH-1:0]                         o_r_id,
    output logic [DATA_WIDTH-1:0]                       o_r_data,
    output logic [1:0]                                  o_r_resp,
    output logic                                        o_r_last,
    output logic                                        o_r_valid,
    input  logic                                        i_r_ready,
    output logic                                        o_ram_en,
    output logic [DATA_WIDTH/8-1:0]                     o_ram_we,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  o_ram_addr,
    output logic [DATA_WIDTH-1:0]                       o_ram_wrdata,
    input  logic [DATA_WIDTH-1:0]                       i_ram_rddata
);

    localparam int OFF       = $clog2(DATA_WIDTH/8);
    localparam int RDQ_DEPTH = RAM_LATENCY + 1;
    localparam int PW        = $clog2(RDQ_DEPTH);
    localparam int CW        = $clog2(RDQ_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_DRAIN} state_t;

    state_t                  r_state;
    logic                    r_prio_rd;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic                    r_illegal;
    logic                    r_err;
    logic [7:0]              r_beat;      // beats accepted (write) or issued to RAM (read)
    logic [7:0]              r_rbeat;     // read beats handed out on R
    logic [RAM_LATENCY-1:0]  r_pend;      // reads in flight inside the RAM pipeline
    logic [DATA_WIDTH-1:0]   r_fifo [RDQ_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_cnt;

    logic                    w_grant_w;
    logic                    w_grant_r;
    logic                    w_aw_hs;
    logic                    w_ar_hs;
    logic                    w_w_hs;
    logic                    w_last_beat;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue;
    logic [3:0]              w_pend_cnt;
    logic [3:0]              w_used;
    logic [ADDR_WIDTH-1:0]   w_next_addr;

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] sb;
        logic [ADDR_WIDTH-1:0] span;
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] res;
        sb   = ADDR_WIDTH'(1) << size;
        span = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        inc  = (a & ~(sb - ADDR_WIDTH'(1))) + sb;
        case (burst)
            2'b01:   res = inc;
            // legal wrap lengths make span a power of two, so masking wraps it
            2'b10:   res = (a & ~(span - ADDR_WIDTH'(1))) | (inc & (span - ADDR_WIDTH'(1)));
            default: res = a;
        endcase
        f_next_addr = res;
    endfunction

    function automatic logic f_illegal(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        f_illegal = (size > 3'(OFF)) || (burst == 2'b11) ||
                    ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                           (len == 8'd7) || (len == 8'd15)));
    endfunction

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        f_inc = (p == PW'(RDQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Contention goes to the flagged channel; a lone request is always granted.
    assign w_grant_w  = i_aw_valid && !(i_ar_valid && r_prio_rd);
    assign w_grant_r  = i_ar_valid && !(i_aw_valid && !r_prio_rd);
    assign o_aw_ready = (r_state == S_IDLE) && w_grant_w;
    assign o_ar_ready = (r_state == S_IDLE) && w_grant_r;
    assign w_aw_hs    = o_aw_ready && i_aw_valid;
    assign w_ar_hs    = o_ar_ready && i_ar_valid;

    assign o_w_ready   = (r_state == S_WRITE);
    assign w_w_hs      = o_w_ready && i_w_valid;
    assign w_last_beat = (r_beat == r_len);
    assign w_next_addr = f_next_addr(r_addr, r_len, r_size, r_burst);

    assign o_b_valid = (r_state == S_WRESP);
    assign o_b_id    = r_id;
    assign o_b_resp  = (r_err || r_illegal) ? 2'b10 : 2'b00;

    assign o_r_valid = (r_cnt != '0);
    assign o_r_data  = r_fifo[r_rd_ptr];
    assign o_r_id    = r_id;
    assign o_r_resp  = r_illegal ? 2'b10 : 2'b00;
    assign o_r_last  = o_r_valid && (r_rbeat == r_len);
    assign w_pop     = o_r_valid && i_r_ready;
    assign w_push    = r_pend[RAM_LATENCY-1];

    always_comb begin
        w_pend_cnt = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            w_pend_cnt = w_pend_cnt + 4'(r_pend[i]);
        end
    end

    // A slot freed by this cycle's pop is reusable at once; that credit is
    // what sustains one beat per cycle with r_ready held high.
    assign w_used  = 4'(r_cnt) + w_pend_cnt - 4'(w_pop);
    assign w_issue = (r_state == S_READ) && (w_used < 4'(RDQ_DEPTH));

    assign o_ram_en     = w_w_hs || w_issue;
    assign o_ram_we     = (w_w_hs && !r_illegal) ? i_w_strb : '0;
    assign o_ram_addr   = r_addr[ADDR_WIDTH-1:OFF];
    assign o_ram_wrdata = i_w_data;

    // FIFO storage carries no reset; only its pointers and count matter.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_illegal ? '0 : i_ram_rddata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_prio_rd <= 1'b1;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
            r_beat    <= '0;
            r_rbeat   <= '0;
            r_pend    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
        end else begin
            r_pend[0] <= w_issue;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_pend[i] <= r_pend[i-1];
            end
            if (w_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
                r_rbeat  <= r_rbeat + 8'd1;
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);

            case (r_state)
                S_IDLE: begin
                    r_beat  <= '0;
                    r_rbeat <= '0;
                    r_err   <= 1'b0;
                    if (w_ar_hs) begin
                        r_id      <= i_ar_id;
                        r_addr    <= i_ar_addr;
                        r_len     <= i_ar_len;
                        r_size    <= i_ar_size;
                        r_burst   <= i_ar_burst;
                        r_illegal <= f_illegal(i_ar_len, i_ar_size, i_ar_burst);
                        r_state   <= S_READ;
                        if (i_aw_valid) r_prio_rd <= 1'b0;
                    end else if (w_aw_hs) begin
                        r_id      <= i_aw_id;
                        r_addr    <= i_aw_addr;
                        r_len     <= i_aw_len;
                        r_size    <= i_aw_size;
                        r_burst   <= i_aw_burst;
                        r_illegal <= f_illegal(i_aw_len, i_aw_size, i_aw_burst);
                        r_state   <= S_WRITE;
                        if (i_ar_valid) r_prio_rd <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_w_hs) begin
                        // the beat counter ends the burst; w_last only feeds the response
                        if (i_w_last != w_last_beat) r_err <= 1'b1;
                        if (w_last_beat) begin
                            r_state <= S_WRESP;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= w_next_addr;
                        end
                    end
                end
                S_WRESP: begin
                    if (i_b_ready) r_state <= S_IDLE;
                end
                S_READ: begin
                    if (w_issue) begin
                        if (w_last_beat) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            r_addr <= w_next_addr;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_rbeat == r_len)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nasti_bram_ctrl.sv
// tb/tb_nasti_bram_ctrl.sv - directed self-checking bench for nasti_bram_ctrl
module tb_nasti_bram_ctrl;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic [7:0]    i_aw_id = '0;
    logic [15:0]   i_aw_addr = '0;
    logic [7:0]    i_aw_len = '0;
    logic [2:0]    i_aw_size = '0;
    logic [1:0]    i_aw_burst = '0;
    logic          i_aw_valid = 1'b0;
    logic          o_aw_ready;
    logic [127:0]  i_w_data = '0;
    logic [15:0]   i_w_strb = '0;
    logic          i_w_last = 1'b0;
    logic          i_w_valid = 1'b0;
    logic          o_w_ready;
    logic [7:0]    o_b_id;
    logic [1:0]    o_b_resp;
    logic          o_b_valid;
    logic          i_b_ready = 1'b0;
    logic [7:0]    i_ar_id = '0;
    logic [15:0]   i_ar_addr = '0;
    logic [7:0]    i_ar_len = '0;
    logic [2:0]    i_ar_size = '0;
    logic [1:0]    i_ar_burst = '0;
    logic          i_ar_valid = 1'b0;
    logic          o_ar_ready;
    logic [7:0]    o_r_id;
    logic [127:0]  o_r_data;
    logic [1:0]    o_r_resp;
    logic          o_r_last;
    logic          o_r_valid;
    logic          i_r_ready = 1'b0;
    logic          o_ram_en;
    logic [15:0]   o_ram_we;
    logic [11:0]   o_ram_addr;
    logic [127:0]  o_ram_wrdata;
    logic [127:0]  i_ram_rddata = '0;

    int n_vec = 0;
    int n_err = 0;

    nasti_bram_ctrl #(.ID_WIDTH(8), .ADDR_WIDTH(16), .DATA_WIDTH(128), .RAM_LATENCY(1)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_aw_id(i_aw_id), .i_aw_addr(i_aw_addr), .i_aw_len(i_aw_len), .i_aw_size(i_aw_size),
        .i_aw_burst(i_aw_burst), .i_aw_valid(i_aw_valid), .o_aw_ready(o_aw_ready),
        .i_w_data(i_w_data), .i_w_strb(i_w_strb), .i_w_last(i_w_last), .i_w_valid(i_w_valid),
        .o_w_ready(o_w_ready),
        .o_b_id(o_b_id), .o_b_resp(o_b_resp), .o_b_valid(o_b_valid), .i_b_ready(i_b_ready),
        .i_ar_id(i_ar_id), .i_ar_addr(i_ar_addr), .i_ar_len(i_ar_len), .i_ar_size(i_ar_size),
        .i_ar_burst(i_ar_burst), .i_ar_valid(i_ar_valid), .o_ar_ready(o_ar_ready),
        .o_r_id(o_r_id), .o_r_data(o_r_data), .o_r_resp(o_r_resp), .o_r_last(o_r_last),
        .o_r_valid(o_r_valid), .i_r_ready(i_r_ready),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_wrdata(o_ram_wrdata), .i_ram_rddata(i_ram_rddata)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [127:0] pat(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 + i[31:0];
        return {w, w, w, w};
    endfunction

    // RAM model, one-cycle read latency
    logic [127:0] mem [4096];
    always @(posedge i_clk) begin
        if (o_ram_en) begin
            if (o_ram_we != '0) begin
                for (int b = 0; b < 16; b++) begin
                    if (o_ram_we[b]) mem[o_ram_addr][b*8 +: 8] = o_ram_wrdata[b*8 +: 8];
                end
            end else begin
                i_ram_rddata <= mem[o_ram_addr];
            end
        end
    end

    // RAM write log
    logic [11:0] wa_log [64];
    logic [15:0] we_log [64];
    int          w_n = 0;
    always @(negedge i_clk) begin
        if (o_ram_en && (o_ram_we != '0) && (w_n < 64)) begin
            wa_log[w_n] = o_ram_addr;
            we_log[w_n] = o_ram_we;
            w_n = w_n + 1;
        end
    end

    logic [127:0] rd_data [16];
    logic         rd_last [16];
    logic [1:0]   rd_resp [16];
    logic [7:0]   rd_id   [16];
    int           rd_cyc  [16];
    logic [1:0]   bresp;
    logic [7:0]   bid;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_aw();
        bit seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge i_clk);
            if (o_aw_ready) seen = 1;
        end
        if (!seen) check("aw_timeout", 0, 1);
        @(posedge i_clk); #1 i_aw_valid = 1'b0;
    endtask

    task automatic wait_ar();
        bit seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge i_clk);
            if (o_ar_ready) seen = 1;
        end
        if (!seen) check("ar_timeout", 0, 1);
        @(posedge i_clk); #1 i_ar_valid = 1'b0;
    endtask

    task automatic set_aw(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [7:0] id);
        i_aw_addr = a; i_aw_len = l; i_aw_size = s; i_aw_burst = b; i_aw_id = id;
        i_aw_valid = 1'b1;
    endtask

    task automatic set_ar(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [7:0] id);
        i_ar_addr = a; i_ar_len = l; i_ar_size = s; i_ar_burst = b; i_ar_id = id;
        i_ar_valid = 1'b1;
    endtask

    task automatic do_w(input logic [127:0] d, input logic [15:0] strb, input logic last);
        bit seen = 0;
        i_w_data = d; i_w_strb = strb; i_w_last = last; i_w_valid = 1'b1;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge i_clk);
            if (o_w_ready) seen = 1;
        end
        if (!seen) check("w_timeout", 0, 1);
        @(posedge i_clk); #1 i_w_valid = 1'b0;
    endtask

    task automatic get_b();
        bit seen = 0;
        i_b_ready = 1'b1;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge i_clk);
            if (o_b_valid) begin
                seen = 1; bresp = o_b_resp; bid = o_b_id;
            end
        end
        if (!seen) begin
            check("b_timeout", 0, 1);
            bresp = 2'bxx; bid = 'x;
        end
        @(posedge i_clk); #1 i_b_ready = 1'b0;
    endtask

    // mode 0: r_ready held high, mode 1: r_ready toggles 1/0
    task automatic collect(input int n_want, input int mode);
        int got = 0;
        for (int c = 0; c < 300 && got < n_want; c++) begin
            @(posedge i_clk); #1;
            i_r_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
            @(negedge i_clk);
            if (o_r_valid && i_r_ready) begin
                rd_data[got] = o_r_data; rd_last[got] = o_r_last;
                rd_resp[got] = o_r_resp; rd_id[got] = o_r_id; rd_cyc[got] = c;
                got++;
            end
        end
        if (got < n_want) check("r_timeout", 128'(got), 128'(n_want));
        @(posedge i_clk); #1 i_r_ready = 1'b0;
    endtask

    task automatic reset_pulse();
        i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
    endtask

    logic [11:0] exp_wa [4];
    logic [15:0] exp_st [4];
    logic [127:0] d1;
    int base;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = pat(i);

        // reset state
        @(negedge i_clk);
        check("rst_aw_ready", o_aw_ready, 0);
        check("rst_ar_ready", o_ar_ready, 0);
        check("rst_w_ready", o_w_ready, 0);
        check("rst_b_valid", o_b_valid, 0);
        check("rst_r_valid", o_r_valid, 0);
        check("rst_ram_en", o_ram_en, 0);
        check("rst_ram_we", o_ram_we, 0);
        @(posedge i_clk); #1 i_rstn = 1'b1;

        // INCR len7 read with r_ready toggling, then with r_ready high
        set_ar(16'h0000, 8'd7, 3'd4, 2'b01, 8'h5A); wait_ar();
        collect(8, 1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("incr_tog_data%0d", k), rd_data[k], pat(k));
            check($sformatf("incr_tog_last%0d", k), rd_last[k], (k == 7));
        end
        check("incr_tog_id", rd_id[0], 8'h5A);
        set_ar(16'h0000, 8'd7, 3'd4, 2'b01, 8'h5B); wait_ar();
        collect(8, 0);
        for (int k = 1; k < 8; k++) begin
            check($sformatf("incr_b2b_gap%0d", k), 128'(rd_cyc[k] - rd_cyc[k-1]), 1);
            check($sformatf("incr_b2b_data%0d", k), rd_data[k], pat(k));
        end

        // illegal size on read: zero data, SLVERR
        set_ar(16'h0040, 8'd0, 3'd5, 2'b01, 8'h33); wait_ar();
        collect(1, 0);
        check("ill_rd_data", rd_data[0], 0);
        check("ill_rd_resp", rd_resp[0], 2'b10);
        check("ill_rd_last", rd_last[0], 1);

        // reset during beat 3 of a len7 read
        set_ar(16'h0000, 8'd7, 3'd4, 2'b01, 8'h44); wait_ar();
        collect(3, 0);
        for (int k = 0; k < 3; k++) check($sformatf("mid_rst_data%0d", k), rd_data[k], pat(k));
        i_rstn = 1'b0;
        @(negedge i_clk);
        check("mid_rst_r_valid", o_r_valid, 0);
        check("mid_rst_ram_en", o_ram_en, 0);
        check("mid_rst_b_valid", o_b_valid, 0);
        check("mid_rst_ar_ready", o_ar_ready, 0);
        @(posedge i_clk); #1 i_rstn = 1'b1;
        i_r_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        check("post_rst_no_r", o_r_valid, 0);
        i_r_ready = 1'b0;
        @(posedge i_clk); #1;
        set_ar(16'h0020, 8'd0, 3'd4, 2'b01, 8'h45); wait_ar();
        collect(1, 0);
        check("post_rst_data", rd_data[0], pat(2));
        check("post_rst_last", rd_last[0], 1);
        check("post_rst_id", rd_id[0], 8'h45);

        // arbitration: both valid together four times -> R, W, R, W
        reset_pulse();
        for (int it = 0; it < 4; it++) begin
            set_aw(16'h1000 + 16'(it * 16), 8'd0, 3'd4, 2'b01, 8'h60);
            set_ar(16'h2000, 8'd0, 3'd4, 2'b01, 8'h61);
            @(negedge i_clk);
            check($sformatf("arb_grant%0d", it), {o_ar_ready, o_aw_ready},
                  ((it % 2) == 0) ? 2'b10 : 2'b01);
            @(posedge i_clk); #1;
            if ((it % 2) == 0) begin
                i_ar_valid = 1'b0;
                collect(1, 0);
                wait_aw();
                do_w(pat(900 + it), 16'hFFFF, 1'b1);
                get_b();
            end else begin
                i_aw_valid = 1'b0;
                do_w(pat(900 + it), 16'hFFFF, 1'b1);
                get_b();
                wait_ar();
                collect(1, 0);
            end
        end

        // single-beat write then read back
        d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        base = w_n;
        set_aw(16'h0010, 8'd0, 3'd4, 2'b01, 8'h11); wait_aw();
        do_w(d1, 16'hFFFF, 1'b1);
        get_b();
        check("wr1_count", 128'(w_n - base), 1);
        check("wr1_addr", wa_log[base], 12'd1);
        check("wr1_we", we_log[base], 16'hFFFF);
        check("wr1_bresp", bresp, 2'b00);
        check("wr1_bid", bid, 8'h11);
        set_ar(16'h0010, 8'd0, 3'd4, 2'b01, 8'h22); wait_ar();
        collect(1, 0);
        check("rd1_data", rd_data[0], d1);
        check("rd1_last", rd_last[0], 1);
        check("rd1_resp", rd_resp[0], 2'b00);
        check("rd1_id", rd_id[0], 8'h22);

        // WRAP len3 write from 0x30 -> words 3,0,1,2
        exp_wa = '{12'd3, 12'd0, 12'd1, 12'd2};
        base = w_n;
        set_aw(16'h0030, 8'd3, 3'd4, 2'b10, 8'h77); wait_aw();
        for (int k = 0; k < 4; k++) do_w(pat(100 + k), 16'hFFFF, (k == 3));
        get_b();
        check("wrap_count", 128'(w_n - base), 4);
        for (int k = 0; k < 4; k++) check($sformatf("wrap_addr%0d", k), wa_log[base + k], exp_wa[k]);
        check("wrap_bresp", bresp, 2'b00);

        // narrow INCR write, w_last early on beat 2
        exp_wa = '{12'd0, 12'd0, 12'd0, 12'd1};
        exp_st = '{16'h00F0, 16'h0F00, 16'hF000, 16'h000F};
        base = w_n;
        set_aw(16'h0004, 8'd3, 3'd2, 2'b01, 8'h88); wait_aw();
        for (int k = 0; k < 4; k++) do_w(pat(200 + k), exp_st[k], (k == 2));
        get_b();
        check("narrow_count", 128'(w_n - base), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("narrow_addr%0d", k), wa_log[base + k], exp_wa[k]);
            check($sformatf("narrow_we%0d", k), we_log[base + k], exp_st[k]);
        end
        check("narrow_bresp", bresp, 2'b10);
        check("narrow_bid", bid, 8'h88);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
